vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Raster timing generator that drives the colour generator. Produces the
//   pixel coordinates (column, row), blank_n, hsync and vsync for 640x480@60.
//   Divides the system clock down to a pixel-rate enable.
//   frame_start lets the game FSM sync to the vertical retrace.
// PARAMETERS
//   CLK_DIV    2    system clocks per pixel (>=1); 50 MHz / 2 = 25 MHz pixel rate
//   H_VISIBLE  640  visible pixels per line
//   H_FRONT    16   horizontal front porch, pixels
//   H_SYNC     96   hsync pulse width, pixels
//   H_BACK     48   horizontal back porch, pixels
//   V_VISIBLE  480  visible lines per frame
//   V_FRONT    10   vertical front porch, lines
//   V_SYNC     2    vsync pulse width, lines
//   V_BACK     33   vertical back porch, lines
//   SYNC_POL   0    sync active level (0 = active-low pulses)
// PORTS
//   clk          in   1   system clock
//   rst          in   1   asynchronous reset, active-low
//   pix_en       out  1   one-clk strobe per pixel; all outputs below update only when it is high
//   column       out  10  horizontal position 0..H_TOTAL-1 (H_TOTAL = 800)
//   row          out  9   vertical position 0..V_VISIBLE-1; forced 0 during vertical blank
//   blank_n      out  1   1 = visible area (column<H_VISIBLE && vcnt<V_VISIBLE)
//   hsync        out  1   horizontal sync, level per SYNC_POL
//   vsync        out  1   vertical sync, level per SYNC_POL
//   frame_start  out  1   one-clk pulse in the cycle that outputs show column 0, row 0
// BEHAVIOUR
// - Divider: div counts 0..CLK_DIV-1 and wraps. pix_en = (div == CLK_DIV-1).
//   With CLK_DIV=1, pix_en is constant 1 after reset.
// - Counters: hcnt is 10 bit and vcnt is 10 bit; both advance only on pix_en.
//   - hcnt wraps H_TOTAL-1 -> 0; on that wrap vcnt increments.
//   - vcnt wraps V_TOTAL-1 -> 0 (V_TOTAL = 525).
//   - Simultaneous wrap of both gives (0,0), which is a new frame.
// - Outputs: all registered and loaded on pix_en from a decode of the current hcnt/vcnt.
//   - column = hcnt.
//   - row = vcnt[8:0] if vcnt < V_VISIBLE, else 9'd0. No aliasing of lines 512..524.
//   - hsync active while H_VISIBLE+H_FRONT <= hcnt < H_VISIBLE+H_FRONT+H_SYNC (656..751).
//   - vsync active while V_VISIBLE+V_FRONT <= vcnt < V_VISIBLE+V_FRONT+V_SYNC (490..491).
//   - frame_start is high for exactly one clk, the clk in which the (0,0) outputs are loaded.
// - Reset (asynchronous, immediate):
//   - div, hcnt, vcnt, column, row = 0; blank_n = 0; frame_start = 0.
//   - hsync and vsync are inactive (= ~SYNC_POL).
//   - The first pix_en after release loads (0,0), blank_n=1 and frame_start=1.
//   - Reset mid-frame abandons the frame; there is no partial-line completion.
// - Frame period: H_TOTAL*V_TOTAL = 420000 pixels = 420000*CLK_DIV clks.
// - No handshake. Downstream samples on pix_en and is combinational from column/row.
// CONFIGURATION
//   VGA_SYNC_DELAY_EN defined:
//     - hsync, vsync and blank_n pass through one extra register stage that updates on pix_en.
//     - They lag column/row by one pixel, to align with a 1-pixel-latency board-RAM colour read.
//     - The stage resets to inactive sync and blank_n=0. frame_start is not delayed.
//   Not defined: hsync/vsync/blank_n are coherent with column/row in the same cycle.
// TESTING
//   1 Release rst, CLK_DIV=2 -> pix_en high every 2nd clk.
//     First pix_en gives column=0, row=0, blank_n=1, frame_start=1 for one clk.
//   2 Step a line -> blank_n=1 at column 639 and 0 at column 640.
//     hsync low for columns 656..751. Column 799 -> 0 with row +1.
//   3 Step a frame -> row 479 then row=0 with blank_n=0 for vcnt 480..524.
//     vsync low for vcnt 490..491. frame_start pulses exactly 840000 clks apart.
//   4 Assert rst at column 300, row 200 -> outputs go to reset values without waiting for clk.
//     After release, restart at (0,0) with frame_start.
//   5 VGA_SYNC_DELAY_EN -> blank_n falls while column=641 and hsync goes low at column 657.
//     frame_start is still coincident with (0,0).
//   6 CLK_DIV=1 -> pix_en constantly 1; frame_start period 420000 clks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate enable, column/row, blank_n, hsync/vsync, frame_start.
// Optional VGA_SYNC_DELAY_EN delays hsync/vsync/blank_n by one pixel behind column/row.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned SYNC_POL  = 0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] column,
    output logic [8:0] row,
    output logic       blank_n,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic             SYNC_ACT  = 1'(SYNC_POL);
    localparam logic             SYNC_IDLE = ~SYNC_ACT;
    // pix_en is a flop mirroring (div == CLK_DIV-1), so its reset value follows div=0
    localparam logic             PIX_EN_RST = 1'(CLK_DIV == 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en_q, pix_en_d;
    logic [9:0]       hcnt_q, hcnt_d;
    logic [9:0]       vcnt_q, vcnt_d;
    logic [9:0]       column_q, column_d;
    logic [8:0]       row_q, row_d;
    logic             blank_q, blank_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             fs_q, fs_d;
`ifdef VGA_SYNC_DELAY_EN
    logic             blank_dly_q, blank_dly_d;
    logic             hsync_dly_q, hsync_dly_d;
    logic             vsync_dly_q, vsync_dly_d;
`endif

    // Divider, raster counters and output decode, all advancing on the pixel strobe
    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        pix_en_d = (div_d == DIV_LAST);
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        column_d = column_q;
        row_d    = row_q;
        blank_d  = blank_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        fs_d     = 1'b0;
`ifdef VGA_SYNC_DELAY_EN
        blank_dly_d = blank_dly_q;
        hsync_dly_d = hsync_dly_q;
        vsync_dly_d = vsync_dly_q;
`endif
        if (pix_en_q) begin
            if (hcnt_q == 10'(H_TOTAL - 1)) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == 10'(V_TOTAL - 1)) ? '0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
            column_d = hcnt_q;
            row_d    = (vcnt_q < 10'(V_VISIBLE)) ? vcnt_q[8:0] : 9'd0;
            blank_d  = (hcnt_q < 10'(H_VISIBLE)) && (vcnt_q < 10'(V_VISIBLE));
            hsync_d  = (hcnt_q >= 10'(HS_START) && hcnt_q < 10'(HS_END)) ? SYNC_ACT : SYNC_IDLE;
            vsync_d  = (vcnt_q >= 10'(VS_START) && vcnt_q < 10'(VS_END)) ? SYNC_ACT : SYNC_IDLE;
            fs_d     = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
`ifdef VGA_SYNC_DELAY_EN
            blank_dly_d = blank_q;
            hsync_dly_d = hsync_q;
            vsync_dly_d = vsync_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q    <= '0;
            pix_en_q <= PIX_EN_RST;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            column_q <= '0;
            row_q    <= '0;
            blank_q  <= 1'b0;
            hsync_q  <= SYNC_IDLE;
            vsync_q  <= SYNC_IDLE;
            fs_q     <= 1'b0;
`ifdef VGA_SYNC_DELAY_EN
            blank_dly_q <= 1'b0;
            hsync_dly_q <= SYNC_IDLE;
            vsync_dly_q <= SYNC_IDLE;
`endif
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            column_q <= column_d;
            row_q    <= row_d;
            blank_q  <= blank_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            fs_q     <= fs_d;
`ifdef VGA_SYNC_DELAY_EN
            blank_dly_q <= blank_dly_d;
            hsync_dly_q <= hsync_dly_d;
            vsync_dly_q <= vsync_dly_d;
`endif
        end
    end

    assign pix_en      = pix_en_q;
    assign column      = column_q;
    assign row         = row_q;
    assign frame_start = fs_q;
`ifdef VGA_SYNC_DELAY_EN
    assign blank_n = blank_dly_q;
    assign hsync   = hsync_dly_q;
    assign vsync   = vsync_dly_q;
`else
    assign blank_n = blank_q;
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line timing, reduced rasters for frame timing.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pix_en;
        logic [9:0] column;
        logic [8:0] row;
        logic       blank_n;
        logic       hsync;
        logic       vsync;
        logic       frame_start;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    longint e = 0;          // clock edges since reset release
    int n_vec = 0;
    int n_err = 0;
    longint last_sm = -1;
    longint last_d1 = -1;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) e <= 0;
        else      e <= e + 1;
    end

    logic       pe_a, bl_a, hs_a, vs_a, fs_a;
    logic [9:0] col_a;
    logic [8:0] row_a;
    logic       pe_b, bl_b, hs_b, vs_b, fs_b;
    logic [9:0] col_b;
    logic [8:0] row_b;
    logic       pe_c, bl_c, hs_c, vs_c, fs_c;
    logic [9:0] col_c;
    logic [8:0] row_c;
    obs_t o_a, o_b, o_c;

    assign o_a = {pe_a, col_a, row_a, bl_a, hs_a, vs_a, fs_a};
    assign o_b = {pe_b, col_b, row_b, bl_b, hs_b, vs_b, fs_b};
    assign o_c = {pe_c, col_c, row_c, bl_c, hs_c, vs_c, fs_c};

    vga_timing_gen u_full (
        .clk(clk), .rst(rst), .pix_en(pe_a), .column(col_a), .row(row_a),
        .blank_n(bl_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(0)
    ) u_small (
        .clk(clk), .rst(rst), .pix_en(pe_b), .column(col_b), .row(row_b),
        .blank_n(bl_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1)
    ) u_div1 (
        .clk(clk), .rst(rst), .pix_en(pe_c), .column(col_c), .row(row_c),
        .blank_n(bl_c), .hsync(hs_c), .vsync(vs_c), .frame_start(fs_c)
    );

    // {blank_n, hsync, vsync} for raster pixel index p (p < 0 means nothing loaded yet)
    function automatic logic [2:0] vid(input longint hv, hf, hsw, hb, vv, vf, vsw, vb,
                                       input bit pol, input longint p);
        longint ht, vt, h, v;
        logic b, hs, vs;
        if (p < 0) return {1'b0, ~pol, ~pol};
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        h  = p % ht;
        v  = (p / ht) % vt;
        b  = (h < hv) && (v < vv);
        hs = (h >= hv + hf && h < hv + hf + hsw) ? pol : ~pol;
        vs = (v >= vv + vf && v < vv + vf + vsw) ? pol : ~pol;
        return {b, hs, vs};
    endfunction

    // Expected outputs after ec clock edges out of reset: the n-th pixel strobe shows pixel n-1
    function automatic obs_t model(input longint d, hv, hf, hsw, hb, vv, vf, vsw, vb,
                                   input bit pol, input longint ec);
        obs_t o;
        longint n, p, ht, vt, h, v;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        n  = ec / d;
        o.pix_en = ((ec % d) == d - 1);
        if (n == 0) begin
            o.column = '0;
            o.row    = '0;
            {o.blank_n, o.hsync, o.vsync} = {1'b0, ~pol, ~pol};
            o.frame_start = 1'b0;
        end else begin
            p = n - 1;
            h = p % ht;
            v = (p / ht) % vt;
            o.column = 10'(h);
            o.row    = (v < vv) ? 9'(v) : 9'd0;
`ifdef VGA_SYNC_DELAY_EN
            {o.blank_n, o.hsync, o.vsync} = vid(hv, hf, hsw, hb, vv, vf, vsw, vb, pol, p - 1);
`else
            {o.blank_n, o.hsync, o.vsync} = vid(hv, hf, hsw, hb, vv, vf, vsw, vb, pol, p);
`endif
            o.frame_start = ((ec % d) == 0) && ((p % (ht * vt)) == 0);
        end
        return o;
    endfunction

    function automatic obs_t m_full(input longint ec);
        return model(2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, ec);
    endfunction
    function automatic obs_t m_small(input longint ec);
        return model(2, 8, 2, 3, 2, 6, 1, 2, 2, 1'b0, ec);
    endfunction
    function automatic obs_t m_div1(input longint ec);
        return model(1, 8, 2, 3, 2, 6, 1, 2, 2, 1'b1, ec);
    endfunction

    task automatic chk(input string nm, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s e=%0d: got pe=%0b col=%0d row=%0d bl=%0b hs=%0b vs=%0b fs=%0b, required pe=%0b col=%0d row=%0d bl=%0b hs=%0b vs=%0b fs=%0b",
                     nm, e, act.pix_en, act.column, act.row, act.blank_n, act.hsync, act.vsync,
                     act.frame_start, exp.pix_en, exp.column, exp.row, exp.blank_n, exp.hsync,
                     exp.vsync, exp.frame_start);
        end
    endtask

    task automatic chk_num(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    // Per-cycle comparison against the model plus hand-derived pins
    always @(negedge clk) begin
        chk("full", o_a, m_full(e));
        chk("small", o_b, m_small(e));
        chk("div1", o_c, m_div1(e));
        if (!rst) begin
            last_sm = -1;
            last_d1 = -1;
        end else begin
`ifdef VGA_SYNC_DELAY_EN
            if (col_a == 10'd640) chk_num("blank_col640", longint'(bl_a), 1);
            if (col_a == 10'd641) chk_num("blank_col641", longint'(bl_a), 0);
            if (col_a == 10'd656) chk_num("hsync_col656", longint'(hs_a), 1);
            if (col_a == 10'd657) chk_num("hsync_col657", longint'(hs_a), 0);
`else
            if (col_a == 10'd639) chk_num("blank_col639", longint'(bl_a), 1);
            if (col_a == 10'd640) chk_num("blank_col640", longint'(bl_a), 0);
            if (col_a == 10'd655) chk_num("hsync_col655", longint'(hs_a), 1);
            if (col_a == 10'd656) chk_num("hsync_col656", longint'(hs_a), 0);
            if (col_a == 10'd751) chk_num("hsync_col751", longint'(hs_a), 0);
            if (col_a == 10'd752) chk_num("hsync_col752", longint'(hs_a), 1);
`endif
            if (fs_b) begin
                if (last_sm < 0) chk_num("small_first_fs", e, 2);
                else             chk_num("small_fs_period", e - last_sm, 330);
                last_sm = e;
            end
            if (fs_c) begin
                if (last_d1 < 0) chk_num("div1_first_fs", e, 1);
                else             chk_num("div1_fs_period", e - last_d1, 165);
                last_d1 = e;
            end
            if (fs_b) chk_num("small_fs_at_origin", longint'({col_b, row_b}), 0);
        end
    end

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3500) @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (col_a == 10'd300) found = 1'b1;
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_col300: got no column 300 within 2000 clks, required column 300");
        end
        // Asynchronous reset mid-line: outputs must clear before the next edge
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_full", o_a, m_full(0));
        chk("async_small", o_b, m_small(0));
        chk("async_div1", o_c, m_div1(0));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (800) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
